// File: rtl/code_lock_pkg.sv
// ============================================================================
// Module : code_lock_pkg
// Brief  : Shared types and constants for the code lock controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package code_lock_pkg;

  localparam int CODE_LEN = 4;
  localparam int DIGIT_W  = 4;
  localparam int TIMER_W  = 16;

  typedef logic [CODE_LEN*DIGIT_W-1:0] code_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4,
    ST_PROG    = 3'd5
  } state_t;

  function automatic logic is_key(input logic valid, input logic [DIGIT_W-1:0] code);
    return valid && (code <= 4'd9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/code_lock_timer.sv
// ============================================================================
// Module : code_lock_timer
// Brief  : Tick counter with restart and terminal-count strobe.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module code_lock_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_restart,
  input  logic         i_tick,
  input  logic [W-1:0] i_limit,
  output logic         o_done
);

  logic [W-1:0] r_cnt;
  logic         w_term;

  assign w_term = (r_cnt == (i_limit - W'(1)));
  // done fires on the tick that completes the count, so the FSM moves on that edge
  assign o_done = i_tick && w_term;

  always_ff @(posedge clk) begin
    if (rst || i_restart) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= w_term ? '0 : r_cnt + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/code_lock_ctrl.sv
// ============================================================================
// Module : code_lock_ctrl
// Brief  : Four-digit keypad lock FSM with failure lockout; passcode
//          programming is available when CODE_LOCK_PROG_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter logic [15:0] DEFAULT_CODE  = 16'h0825,
  parameter int          MAX_FAIL      = 3,
  parameter int          TIMEOUT_TICKS = 10,
  parameter int          OPEN_TICKS    = 20,
  parameter int          LOCKOUT_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       clear,
  input  logic       relock,
  input  logic       prog_req,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] digit_cnt,
  output logic [1:0] fail_cnt,
  output logic [2:0] state
);

  localparam logic [1:0] c_max_fail = 2'(MAX_FAIL);

  state_t               r_state;
  code_t                r_digits;
  logic [2:0]           r_digit_cnt;
  logic [1:0]           r_fail_cnt;
  logic                 r_unlocked;
  logic                 r_alarm;

  logic                 w_key;
  logic                 w_restart;
  logic                 w_done;
  logic                 w_prog_go;
  logic [TIMER_W-1:0]   w_limit;
  logic [1:0]           w_fail_next;
  code_t                w_shifted;
  code_t                w_passcode;

`ifdef CODE_LOCK_PROG_EN
  code_t r_passcode;
  assign w_passcode = r_passcode;
  assign w_prog_go  = prog_req;
`else
  logic w_unused_prog;
  assign w_passcode    = DEFAULT_CODE;
  assign w_prog_go     = 1'b0;
  assign w_unused_prog = prog_req;
`endif

  assign w_key       = is_key(key_valid, key_code);
  assign w_shifted   = {r_digits[CODE_LEN*DIGIT_W-DIGIT_W-1:0], key_code};
  assign w_fail_next = r_fail_cnt + 2'd1;

  // Restart on every condition that changes state, plus each accepted key
  always_comb begin
    w_restart = 1'b0;
    w_limit   = TIMER_W'(TIMEOUT_TICKS);
    case (r_state)
      ST_IDLE:            w_restart = w_key;
      ST_ENTRY, ST_PROG:  w_restart = clear | w_key | w_done;
      ST_CHECK:           w_restart = 1'b1;
      ST_OPEN: begin
        w_restart = relock | w_prog_go | w_done;
        w_limit   = TIMER_W'(OPEN_TICKS);
      end
      ST_LOCKOUT: begin
        w_restart = w_done;
        w_limit   = TIMER_W'(LOCKOUT_TICKS);
      end
      default:            w_restart = 1'b1;
    endcase
  end

  code_lock_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk       (clk),
    .rst       (reset),
    .i_restart (w_restart),
    .i_tick    (tick),
    .i_limit   (w_limit),
    .o_done    (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_digits    <= '0;
      r_digit_cnt <= 3'd0;
      r_fail_cnt  <= 2'd0;
      r_unlocked  <= 1'b0;
      r_alarm     <= 1'b0;
`ifdef CODE_LOCK_PROG_EN
      r_passcode  <= DEFAULT_CODE;
`endif
    end else begin
      r_unlocked <= 1'b0;
      r_alarm    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_key) begin
            r_digits    <= w_shifted;
            r_digit_cnt <= 3'd1;
            r_state     <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (clear) begin
            r_digit_cnt <= 3'd0;
            r_state     <= ST_IDLE;
          end else if (w_key) begin
            r_digits    <= w_shifted;
            r_digit_cnt <= r_digit_cnt + 3'd1;
            if (r_digit_cnt == 3'd3) r_state <= ST_CHECK;
          end else if (w_done) begin
            r_digit_cnt <= 3'd0;
            r_state     <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          r_digit_cnt <= 3'd0;
          if (r_digits == w_passcode) begin
            r_fail_cnt <= 2'd0;
            r_unlocked <= 1'b1;
            r_state    <= ST_OPEN;
          end else begin
            r_fail_cnt <= w_fail_next;
            if (w_fail_next >= c_max_fail) begin
              r_alarm <= 1'b1;
              r_state <= ST_LOCKOUT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_OPEN: begin
          if (relock) begin
            r_state <= ST_IDLE;
          end else if (w_prog_go) begin
            r_digit_cnt <= 3'd0;
            r_state     <= ST_PROG;
          end else if (w_done) begin
            r_state <= ST_IDLE;
          end else begin
            r_unlocked <= 1'b1;
          end
        end
        ST_LOCKOUT: begin
          if (w_done) begin
            r_fail_cnt <= 2'd0;
            r_state    <= ST_IDLE;
          end else begin
            r_alarm <= 1'b1;
          end
        end
`ifdef CODE_LOCK_PROG_EN
        ST_PROG: begin
          if (clear) begin
            r_digit_cnt <= 3'd0;
            r_state     <= ST_IDLE;
          end else if (w_key) begin
            r_digits <= w_shifted;
            if (r_digit_cnt == 3'd3) begin
              r_passcode  <= w_shifted;
              r_digit_cnt <= 3'd0;
              r_state     <= ST_IDLE;
            end else begin
              r_digit_cnt <= r_digit_cnt + 3'd1;
            end
          end else if (w_done) begin
            r_digit_cnt <= 3'd0;
            r_state     <= ST_IDLE;
          end
        end
`endif
        default: begin
          r_digit_cnt <= 3'd0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign unlocked  = r_unlocked;
  assign alarm     = r_alarm;
  assign digit_cnt = r_digit_cnt;
  assign fail_cnt  = r_fail_cnt;
  assign state     = r_state;

endmodule

`default_nettype wire
